// File: rtl/intf2_bus_arbiter.sv
// Purpose : round-robin arbiter for a shared intf2 bus; one owner at a time drives abc/def.
// Latency : grant registered, 1 cycle after req_i rises in IDLE; bus_abc/def combinational from owner.
// Backpressure: owners hold the bus while req_i[owner] is high, forcibly released after MAX_HOLD cycles.
//
// Ports:
//   clk, rst_n       - clock (rising edge) and async active-low reset
//   req_i[NUM_REQ]   - per-requester level-sensitive bus request
//   abc_i/def_i      - per-requester values muxed onto the shared bus by the owner
//   gnt_o            - registered one-hot grant
//   bus_abc_o/def_o  - shared bus values, 0 when no grant is active
//   bus_valid_o      - high while in GRANT
//   timeout_o        - one-cycle pulse in the COOLDOWN cycle after a forced release
module intf2_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] abc_i,
  input  logic [NUM_REQ-1:0] def_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               bus_abc_o,
  output logic               bus_def_o,
  output logic               bus_valid_o,
  output logic               timeout_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_owner;
  logic [7:0]           r_hold_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_timeout;

  logic                 w_sel_vld;
  logic [PW-1:0]        w_sel_idx;
  logic [NUM_REQ-1:0]   w_sel_onehot;
  logic                 w_owner_req;
  logic                 w_at_limit;
  logic [PW-1:0]        w_next_ptr;

  // (base + off) mod NUM_REQ; both operands are below NUM_REQ so one subtraction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(32'(base)) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PW-1:0];
  endfunction

  // Scan from the farthest offset down to offset 0 so the nearest requester
  // at or after rr_ptr is the last (winning) assignment.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[wrap_add(r_rr_ptr, i)]) begin
        w_sel_vld = 1'b1;
        w_sel_idx = wrap_add(r_rr_ptr, i);
      end
    end
  end

  assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
  assign w_owner_req  = req_i[r_owner];
  assign w_at_limit   = (r_hold_cnt == 8'(MAX_HOLD));
  assign w_next_ptr   = wrap_add(r_owner, 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, COOLDOWN: begin
          // COOLDOWN always leaves after one cycle, giving the mandatory gap.
          r_timeout <= 1'b0;
          if (w_sel_vld) begin
            r_state    <= GRANT;
            r_owner    <= w_sel_idx;
            r_gnt      <= w_sel_onehot;
            r_hold_cnt <= 8'd1;
          end else begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!w_owner_req) begin
            // Voluntary release wins over a simultaneous limit hit: no timeout.
            r_state    <= COOLDOWN;
            r_gnt      <= '0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= w_next_ptr;
          end else if (w_at_limit) begin
            r_state    <= COOLDOWN;
            r_gnt      <= '0;
            r_timeout  <= 1'b1;
            r_hold_cnt <= '0;
            r_rr_ptr   <= w_next_ptr;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
            r_timeout  <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_gnt     <= '0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign timeout_o   = r_timeout;
  assign bus_valid_o = (r_state == GRANT);
  assign bus_abc_o   = bus_valid_o & abc_i[r_owner];
  assign bus_def_o   = bus_valid_o & def_i[r_owner];

endmodule

// File: tb/tb_intf2_bus_arbiter.sv
// Purpose : directed checks of intf2_bus_arbiter at MAX_HOLD = 4, 2 and 3.
// Latency : checks sample 1 time unit after each rising edge.
// Backpressure: n/a (bench drives req_i levels directly).
module tb_intf2_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] abc;
  logic [3:0] def;

  logic [3:0] gnt4, gnt2, gnt3;
  logic       babc4, bdef4, bval4, to4;
  logic       babc2, bdef2, bval2, to2;
  logic       babc3, bdef3, bval3, to3;

  int checks = 0;
  int passes = 0;

  logic [3:0] exp_g;
  logic       exp_t;
  logic       exp_b;

  intf2_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .abc_i(abc), .def_i(def),
    .gnt_o(gnt4), .bus_abc_o(babc4), .bus_def_o(bdef4), .bus_valid_o(bval4), .timeout_o(to4)
  );

  intf2_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(2)) u_dut_h2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .abc_i(abc), .def_i(def),
    .gnt_o(gnt2), .bus_abc_o(babc2), .bus_def_o(bdef2), .bus_valid_o(bval2), .timeout_o(to2)
  );

  intf2_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(3)) u_dut_h3 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .abc_i(abc), .def_i(def),
    .gnt_o(gnt3), .bus_abc_o(babc3), .bus_def_o(bdef3), .bus_valid_o(bval3), .timeout_o(to3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    abc   = '0;
    def   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111; abc = 4'b1111; def = 4'b1111;
    #3;
    checks++; if ({gnt4, gnt2, gnt3} !== 12'h000) $display("FAIL reset_gnt: got %h want 000", {gnt4, gnt2, gnt3}); else passes++;
    checks++; if ({bval4, bval2, bval3, to4, to2, to3} !== 6'b0) $display("FAIL reset_valid_timeout: got %b want 000000", {bval4, bval2, bval3, to4, to2, to3}); else passes++;
    checks++; if ({babc4, bdef4, babc2, bdef2, babc3, bdef3} !== 6'b0) $display("FAIL reset_bus: got %b want 000000", {babc4, bdef4, babc2, bdef2, babc3, bdef3}); else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({gnt4, bval4} !== 5'b0) $display("FAIL reset_held_with_req: got %b want 00000", {gnt4, bval4}); else passes++;
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    abc = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_g = (c <= 3) ? 4'b0100 : 4'b0000;
      exp_b = (c <= 3);
      checks++; if (gnt4 !== exp_g) $display("FAIL single_gnt c%0d: got %b want %b", c, gnt4, exp_g); else passes++;
      checks++; if (bval4 !== exp_b) $display("FAIL single_valid c%0d: got %b want %b", c, bval4, exp_b); else passes++;
      checks++; if (babc4 !== exp_b) $display("FAIL single_abc c%0d: got %b want %b", c, babc4, exp_b); else passes++;
      checks++; if (to4 !== 1'b0) $display("FAIL single_timeout c%0d: got %b want 0", c, to4); else passes++;
      if (c == 2) begin
        abc = 4'b1011;
        #1;
        checks++; if (babc4 !== 1'b0) $display("FAIL single_abc_track: got %b want 0", babc4); else passes++;
        abc = 4'b0100;
      end
      if (c == 3) req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    int phase;
    int own;
    do_reset();
    def = 4'b0101;
    abc = 4'b0011;
    req = 4'b1111;
    for (int c = 1; c <= 13; c++) begin
      tick();
      phase = (c - 1) % 3;
      own   = ((c - 1) / 3) % 4;
      exp_g = (phase < 2) ? 4'(1 << own) : 4'b0000;
      exp_t = (phase == 2);
      checks++; if (gnt2 !== exp_g) $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt2, exp_g); else passes++;
      checks++; if (to2 !== exp_t) $display("FAIL rr_timeout c%0d: got %b want %b", c, to2, exp_t); else passes++;
      if (phase < 2) begin
        exp_b = (own == 0 || own == 2);
        checks++; if (bdef2 !== exp_b) $display("FAIL rr_def c%0d: got %b want %b", c, bdef2, exp_b); else passes++;
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 4'b1000;
    tick();
    checks++; if (gnt4 !== 4'b1000) $display("FAIL wrap_owner3: got %b want 1000", gnt4); else passes++;
    req = 4'b0000;
    tick();
    checks++; if ({gnt4, to4} !== 5'b00000) $display("FAIL wrap_cooldown: got %b want 00000", {gnt4, to4}); else passes++;
    req = 4'b0101;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_g = (c <= 4) ? 4'b0001 : ((c == 5) ? 4'b0000 : 4'b0100);
      exp_t = (c == 5);
      checks++; if (gnt4 !== exp_g) $display("FAIL wrap_gnt c%0d: got %b want %b", c, gnt4, exp_g); else passes++;
      checks++; if (to4 !== exp_t) $display("FAIL wrap_timeout c%0d: got %b want %b", c, to4, exp_t); else passes++;
    end
  endtask

  task automatic test_deassert_at_limit();
    do_reset();
    req = 4'b0010;
    repeat (4) tick();
    checks++; if (gnt4 !== 4'b0010) $display("FAIL dal_4th_cycle: got %b want 0010", gnt4); else passes++;
    req = 4'b0000;
    tick();
    checks++; if ({gnt4, bval4, to4} !== 6'b0) $display("FAIL dal_cooldown: got %b want 000000", {gnt4, bval4, to4}); else passes++;
    tick();
    checks++; if ({gnt4, to4} !== 5'b0) $display("FAIL dal_idle: got %b want 00000", {gnt4, to4}); else passes++;
  endtask

  task automatic test_sole_timeout();
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 11) begin
        exp_g = 4'b0000;
        exp_t = 1'b0;
      end else begin
        exp_g = (((c - 1) % 4) < 3) ? 4'b0010 : 4'b0000;
        exp_t = (((c - 1) % 4) == 3);
      end
      checks++; if (gnt3 !== exp_g) $display("FAIL sole_gnt c%0d: got %b want %b", c, gnt3, exp_g); else passes++;
      checks++; if (to3 !== exp_t) $display("FAIL sole_timeout c%0d: got %b want %b", c, to3, exp_t); else passes++;
      if (c == 10) req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    abc = 4'b1111;
    req = 4'b0100;
    tick();
    checks++; if (gnt4 !== 4'b0100) $display("FAIL rmid_first: got %b want 0100", gnt4); else passes++;
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    checks++; if (gnt4 !== 4'b0010) $display("FAIL rmid_from_ptr3: got %b want 0010", gnt4); else passes++;
    tick();
    checks++; if ({gnt4, bval4, babc4} !== 6'b001011) $display("FAIL rmid_2nd_cycle: got %b want 001011", {gnt4, bval4, babc4}); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if ({gnt4, bval4, babc4, to4} !== 7'b0) $display("FAIL rmid_async_drop: got %b want 0000000", {gnt4, bval4, babc4, to4}); else passes++;
    tick();
    req = 4'b1010;
    rst_n = 1'b1;
    tick();
    checks++; if ({gnt4, to4} !== 5'b00100) $display("FAIL rmid_regrant_ptr0: got %b want 00100", {gnt4, to4}); else passes++;
    tick();
    checks++; if (gnt4 !== 4'b0010) $display("FAIL rmid_hold: got %b want 0010", gnt4); else passes++;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    abc = '0;
    def = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_deassert_at_limit();
    test_sole_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/intf2_bus_arbiter.md
INTF2_BUS_ARBITER -- requirements
Module: intf2_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum consecutive grant cycles per tenure (range 1..255).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_i  input  NUM_REQ  per-requester bus request, level-sensitive.
REQ-006 The block SHALL have port abc_i  input  NUM_REQ  per-requester abc value.
REQ-007 The block SHALL have port def_i  input  NUM_REQ  per-requester def value.
REQ-008 The block SHALL have port gnt_o  output  NUM_REQ  one-hot grant, registered.
REQ-009 The block SHALL have port bus_abc_o  output  1  shared intf2 abc, driving the all_in modport side.
REQ-010 The block SHALL have port bus_def_o  output  1  shared intf2 def.
REQ-011 The block SHALL have port bus_valid_o  output  1  high while a grant is active.
REQ-012 The block SHALL have port timeout_o  output  1  one-cycle pulse on a forced release.

Function
REQ-013 The block SHALL implement FSM states IDLE, GRANT and COOLDOWN, and SHALL hold a round-robin pointer rr_ptr of width clog2(NUM_REQ).
REQ-014 In IDLE or COOLDOWN with any req_i bit set, the block SHALL select the first set index at or after rr_ptr, wrapping modulo NUM_REQ, and SHALL enter GRANT with gnt_o one-hot on that index at the next edge.
REQ-015 Grant latency from a req_i rise in IDLE SHALL be exactly 1 cycle.
REQ-016 In IDLE or COOLDOWN with req_i == 0, the next state SHALL be IDLE.
REQ-017 On entering GRANT, hold_cnt SHALL load 1; each further GRANT cycle SHALL increment it; hold_cnt SHALL never exceed MAX_HOLD.
REQ-018 In GRANT, if req_i[owner] is 0 at an edge, the block SHALL go to COOLDOWN, clear gnt_o and leave timeout_o at 0.
REQ-019 In GRANT, if req_i[owner] is 1 and hold_cnt == MAX_HOLD at an edge, the block SHALL go to COOLDOWN, clear gnt_o and pulse timeout_o for exactly that COOLDOWN cycle.
REQ-020 When a deassert and hold_cnt == MAX_HOLD occur together, the deassert SHALL take priority and timeout_o SHALL stay 0.
REQ-021 On every exit from GRANT, rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-022 COOLDOWN SHALL last exactly one cycle, giving a minimum one-cycle gap with gnt_o == 0 between any two tenures, including regrant to the same requester.
REQ-023 A requester that times out and is the sole requester SHALL be regranted after the one COOLDOWN cycle.
REQ-024 bus_valid_o SHALL equal (state == GRANT).
REQ-025 bus_abc_o and bus_def_o SHALL combinationally equal abc_i[owner] and def_i[owner] while bus_valid_o is 1, and SHALL be 0 otherwise.
REQ-026 gnt_o SHALL never have more than one bit set.
REQ-027 Changes to req_i of non-owners during GRANT SHALL not affect the current tenure.

Reset
REQ-028 While rst_n is 0, the block SHALL immediately (asynchronously) force state IDLE, rr_ptr 0, hold_cnt 0, gnt_o 0, bus_valid_o 0, bus_abc_o 0, bus_def_o 0 and timeout_o 0.
REQ-029 Reset asserted mid-tenure SHALL drop the grant without a timeout pulse; after rst_n rises, the first arbitration SHALL start from index 0.

Verification
REQ-030 Single requester: req_i=4'b0100 held 3 cycles, then 0 -> gnt_o=4'b0100 for 3 cycles starting 1 cycle after req, then COOLDOWN, then IDLE; bus_abc_o tracks abc_i[2] only while granted.
REQ-031 Round robin: req_i=4'b1111 continuously, MAX_HOLD=2 -> grant order 0,1,2,3,0 with 2-cycle tenures, 1-cycle gaps and a timeout_o pulse after each tenure.
REQ-032 Wrap and skip: after a tenure by 3, req_i=4'b0101 -> the next grant goes to 0, then to 2.
REQ-033 Simultaneous deassert and limit: MAX_HOLD=4, owner drops req on its 4th grant cycle -> COOLDOWN with timeout_o=0.
REQ-034 Sole requester timeout: MAX_HOLD=3, req_i=4'b0010 held 10 cycles -> pattern of 3 granted cycles, 1 gap, 3 granted cycles, with timeout_o pulsing in each gap.
REQ-035 Reset mid-tenure: rst_n=0 on the 2nd grant cycle of requester 1 -> gnt_o=0 without waiting for a clock edge; after release with req_i=4'b1010, requester 1 is granted first from pointer 0.
